muldiv_unit: RTL

//  Iterative RV32M/RV64M multiply/divide unit; companion to the combinational integer ALU.

---
 rtl/muldiv_unit_pkg.sv | 48 ++++
 rtl/muldiv_div_core.sv | 67 ++++++
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
//   f3OpMul        : funct3 encoding of the M-extension ops (OP, funct7=0000001)
//   muldiv_state_t : control FSM state encoding
//   res_src_t      : which datapath drives the result while in DONE
//   FUNCT7_MULDIV  : funct7 value that selects this unit in the decoder
package muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } f3OpMul;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_MUL = 2'd1,
    SRC_DIV = 2'd2
  } res_src_t;

  // rs1 is treated as two's complement for these ops
  function automatic logic f3_a_signed(input f3OpMul op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic f3_b_signed(input f3OpMul op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic f3_is_rem(input f3OpMul op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor and clear the partial remainder
//   step       : perform one shift/trial-subtract iteration
//   dividend   : unsigned dividend (sampled on start)
//   divisor    : unsigned divisor (sampled on start, must be non-zero)
//   quotient   : quotient, valid after XLEN steps
//   remainder  : remainder, valid after XLEN steps
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The dividend is shifted out of the top of quo_q while quotient bits enter
  // at the bottom, so one register serves both roles.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      // diff[XLEN] is the borrow: set means the trial subtraction failed
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit sitting beside the integer ALU.
// Operands arrive over an in_valid/in_ready handshake, one XLEN result leaves
// over an out_valid/out_ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : operands and funct3 valid
//   in_ready    : unit can accept (IDLE only)
//   in_funct3   : M-extension op (f3OpMul)
//   in_a, in_b  : rs1, rs2
//   kill        : abort the in-flight op / drop an unconsumed result
//   out_valid   : result valid
//   out_ready   : consumer takes the result
//   out_t       : result
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a
// combinational 2*XLEN multiplier; otherwise a shift-add loop is used and no
// multiplier is inferred. Division is always iterative.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_MUL  | shift-add multiply on magnitudes, one bit per cycle
// ST_DIV  | restoring divide on magnitudes, one bit per cycle
// ST_DONE | result presented, held until out_valid&&out_ready
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_t
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  f3OpMul            op_q, op_d;
  res_src_t          src_q, src_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  f3OpMul            in_op;
  logic              a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero, div_ovf, is_div_in;
  logic [XLEN:0]     mul_sum;

  logic              div_start, div_step;
  logic [XLEN-1:0]   div_quo, div_rem;

  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   div_sel, div_fix;

  // Operand decode, only meaningful in the accepting cycle
  always_comb begin
    in_op     = f3OpMul'(in_funct3);
    is_div_in = in_funct3[2];
    a_neg_in  = in_a[XLEN-1] & f3_a_signed(in_op);
    b_neg_in  = in_b[XLEN-1] & f3_b_signed(in_op);
    a_mag     = a_neg_in ? (~in_a + 1'b1) : in_a;
    b_mag     = b_neg_in ? (~in_b + 1'b1) : in_b;
    b_zero    = (in_b == '0);
    div_ovf   = (in_a == MOST_NEG) && (in_b == '1) && ((in_op == DIV) || (in_op == REM));
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 2*XLEN makes one unsigned multiply cover
  // all four signedness variants modulo 2^(2*XLEN).
  logic [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_prod = {{XLEN{a_neg_in}}, in_a} * {{XLEN{b_neg_in}}, in_b};
  end
`endif

  // One shift-add step; carry out of the upper half lands in bit XLEN
  always_comb begin
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    neg_d     = neg_q;
    res_d     = res_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    div_step  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          cnt_d = CNT_LOAD;
          if (is_div_in) begin
            // REM follows the dividend's sign, DIV the xor of both signs
            neg_d = f3_is_rem(in_op) ? a_neg_in : (a_neg_in ^ b_neg_in);
            if (b_zero) begin
              src_d   = SRC_RES;
              res_d   = f3_is_rem(in_op) ? in_a : '1;
              state_d = ST_DONE;
            end else if (div_ovf) begin
              src_d   = SRC_RES;
              res_d   = f3_is_rem(in_op) ? '0 : in_a;
              state_d = ST_DONE;
            end else begin
              src_d     = SRC_DIV;
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            src_d   = SRC_RES;
            res_d   = (in_op == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d = ST_DONE;
`else
            neg_d   = a_neg_in ^ b_neg_in;
            mcand_d = a_mag;
            prod_d  = {{XLEN{1'b0}}, b_mag};
            src_d   = SRC_MUL;
            state_d = ST_MUL;
`endif
          end
        end
      end

      ST_MUL: begin
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d   = ST_IDLE;
      div_start = 1'b0;
      div_step  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MUL;
      src_q   <= SRC_RES;
      neg_q   <= 1'b0;
      res_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign fix-up is applied on the way out; registers stay frozen in DONE so
  // out_t is stable for as long as the consumer stalls.
  always_comb begin
    mul_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
    div_sel = f3_is_rem(op_q) ? div_rem : div_quo;
    div_fix = neg_q ? (~div_sel + 1'b1) : div_sel;
    out_t   = '0;
    if (state_q == ST_DONE) begin
      unique case (src_q)
        SRC_MUL: out_t = (op_q == MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        SRC_DIV: out_t = div_fix;
        default: out_t = res_q;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

endmodule
